// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, BCD sizing, default parameters and BCD increment helper
package game_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;
  localparam int BCD_W = 4;
  localparam int DIGITS = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_START_LIVES = 3;
  localparam int DEF_OVER_FRAMES = 120;
  function automatic logic [DIGITS*BCD_W-1:0] bcd_inc(input logic [DIGITS*BCD_W-1:0] v);
    logic [DIGITS*BCD_W-1:0] r;
    logic c;
    r = v;
    c = (v != 16'h9999);
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[i*BCD_W +: BCD_W] == BCD_W'(9)) r[i*BCD_W +: BCD_W] = '0;
        else begin
          r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + BCD_W'(1);
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stable-count debouncer and one-cycle press pulse
module button_debounce import game_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q;
  logic level_q, level_d;
  logic press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    level_d = level_q;
    cnt_d = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = s2_q;
      else cnt_d = cnt_q + CW'(1);
    end
    press_d = level_d & ~level_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= button;
      s2_q <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q <= cnt_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: IDLE/PLAY/PAUSE/OVER game FSM with BCD score, lives and frame tick from vsync
module game_sequencer import game_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int START_LIVES = DEF_START_LIVES,
  parameter int OVER_FRAMES = DEF_OVER_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        button,
  input  logic        vs,
  input  logic        hit,
  input  logic        miss,
  output logic        play_en,
  output logic [1:0]  state,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        frame_tick
);
  localparam int FW = $clog2(OVER_FRAMES + 1);
  state_e state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic vs_s1_q, vs_s2_q, vs_p_q;
  logic [2:0] vld_q;
  logic frame_tick_q, frame_tick_d;
  logic press;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk),
    .rst_n(rst_n),
    .button(button),
    .press(press)
  );
  // vld_q gates the edge detector until the vs pipeline holds real samples, so a low vs at reset release is not an edge
  always_comb begin
    frame_tick_d = vld_q[2] & vs_p_q & ~vs_s2_q;
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    fcnt_d = fcnt_q;
    case (state_q)
      ST_IDLE: if (press) begin
        state_d = ST_PLAY;
        score_d = '0;
        lives_d = 2'(START_LIVES);
      end
      ST_PLAY: begin
        if (hit) score_d = bcd_inc(score_q);
        if (press) state_d = ST_PAUSE;
        if (miss) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d = ST_OVER;
            fcnt_d = '0;
          end
        end
      end
      ST_PAUSE: if (press) state_d = ST_PLAY;
      default: if (frame_tick_q) begin
        if (fcnt_q == FW'(OVER_FRAMES - 1)) state_d = ST_IDLE;
        else fcnt_d = fcnt_q + FW'(1);
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      lives_q <= '0;
      fcnt_q <= '0;
      vs_s1_q <= 1'b1;
      vs_s2_q <= 1'b1;
      vs_p_q <= 1'b1;
      vld_q <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      fcnt_q <= fcnt_d;
      vs_s1_q <= vs;
      vs_s2_q <= vs_s1_q;
      vs_p_q <= vs_s2_q;
      vld_q <= {vld_q[1:0], 1'b1};
      frame_tick_q <= frame_tick_d;
    end
  end
  assign play_en = (state_q == ST_PLAY);
  assign state = state_q;
  assign score = score_q;
  assign lives = lives_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenario tests for game_sequencer with short debounce and over timers
module tb_game_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button = 1'b0;
  logic vs = 1'b1;
  logic hit = 1'b0;
  logic miss = 1'b0;
  logic play_en, frame_tick;
  logic [1:0] state, lives;
  logic [15:0] score;
  int checks = 0;
  int failures = 0;
  int ticks = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_tick) ticks++;
  game_sequencer #(.DEBOUNCE_CYCLES(4), .START_LIVES(3), .OVER_FRAMES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .button(button),
    .vs(vs),
    .hit(hit),
    .miss(miss),
    .play_en(play_en),
    .state(state),
    .score(score),
    .lives(lives),
    .frame_tick(frame_tick)
  );
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press_button;
    button = 1'b1;
    cyc(8);
    button = 1'b0;
    cyc(8);
  endtask
  task automatic pulse_hit(input int n);
    hit = 1'b1;
    cyc(n);
    hit = 1'b0;
    cyc(1);
  endtask
  task automatic pulse_miss;
    miss = 1'b1;
    cyc(1);
    miss = 1'b0;
    cyc(1);
  endtask
  task automatic vs_frame;
    vs = 1'b0;
    cyc(3);
    vs = 1'b1;
    cyc(6);
  endtask
  task automatic test_reset;
    cyc(2);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d want=0", state); end
    checks++; if (score !== 16'h0000) begin failures++; $display("FAIL rst_score got=%h want=0000", score); end
    checks++; if (lives !== 2'd0) begin failures++; $display("FAIL rst_lives got=%0d want=0", lives); end
    checks++; if (play_en !== 1'b0 || frame_tick !== 1'b0) begin failures++; $display("FAIL rst_outs got=%b%b want=00", play_en, frame_tick); end
    rst_n = 1'b1;
    cyc(6);
    checks++; if (state !== 2'd0 || ticks !== 0) begin failures++; $display("FAIL post_rst got state=%0d ticks=%0d want 0/0", state, ticks); end
  endtask
  task automatic test_start;
    button = 1'b1;
    cyc(3);
    button = 1'b0;
    cyc(6);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL bounce_ignored got=%0d want=0", state); end
    button = 1'b1;
    cyc(6);
    button = 1'b0;
    cyc(10);
    checks++; if (state !== 2'd1 || play_en !== 1'b1) begin failures++; $display("FAIL start_state got=%0d/%b want=1/1", state, play_en); end
    checks++; if (lives !== 2'd3) begin failures++; $display("FAIL start_lives got=%0d want=3", lives); end
    checks++; if (score !== 16'h0000) begin failures++; $display("FAIL start_score got=%h want=0000", score); end
  endtask
  task automatic test_hits;
    pulse_hit(95);
    checks++; if (score !== 16'h0095) begin failures++; $display("FAIL score_95 got=%h want=0095", score); end
    pulse_hit(10);
    checks++; if (score !== 16'h0105) begin failures++; $display("FAIL score_105 got=%h want=0105", score); end
  endtask
  task automatic test_pause;
    press_button;
    checks++; if (state !== 2'd2 || play_en !== 1'b0) begin failures++; $display("FAIL pause_state got=%0d/%b want=2/0", state, play_en); end
    hit = 1'b1;
    miss = 1'b1;
    cyc(1);
    hit = 1'b0;
    miss = 1'b0;
    cyc(1);
    checks++; if (score !== 16'h0105 || lives !== 2'd3) begin failures++; $display("FAIL pause_hold got=%h/%0d want=0105/3", score, lives); end
    press_button;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL resume got=%0d want=1", state); end
  endtask
  task automatic test_miss;
    pulse_miss;
    checks++; if (lives !== 2'd2) begin failures++; $display("FAIL miss1 got=%0d want=2", lives); end
    pulse_miss;
    checks++; if (lives !== 2'd1 || state !== 2'd1) begin failures++; $display("FAIL miss2 got=%0d/%0d want=1/1", lives, state); end
  endtask
  task automatic test_over;
    int t0;
    t0 = ticks;
    hit = 1'b1;
    miss = 1'b1;
    cyc(1);
    hit = 1'b0;
    miss = 1'b0;
    cyc(1);
    checks++; if (score !== 16'h0106) begin failures++; $display("FAIL over_score got=%h want=0106", score); end
    checks++; if (lives !== 2'd0 || state !== 2'd3 || play_en !== 1'b0) begin failures++; $display("FAIL over_state got=%0d/%0d/%b want=0/3/0", lives, state, play_en); end
    press_button;
    pulse_hit(1);
    checks++; if (state !== 2'd3 || score !== 16'h0106) begin failures++; $display("FAIL over_ignore got=%0d/%h want=3/0106", state, score); end
    vs_frame;
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL over_frame1 got=%0d want=3", state); end
    vs_frame;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL over_idle got=%0d want=0", state); end
    checks++; if (ticks !== t0 + 2) begin failures++; $display("FAIL tick_count got=%0d want=%0d", ticks, t0 + 2); end
    pulse_hit(1);
    pulse_miss;
    checks++; if (score !== 16'h0106 || lives !== 2'd0) begin failures++; $display("FAIL idle_hold got=%h/%0d want=0106/0", score, lives); end
  endtask
  task automatic test_saturate;
    press_button;
    checks++; if (state !== 2'd1 || score !== 16'h0000 || lives !== 2'd3) begin failures++; $display("FAIL restart got=%0d/%h/%0d want=1/0000/3", state, score, lives); end
    pulse_hit(9999);
    checks++; if (score !== 16'h9999) begin failures++; $display("FAIL score_9999 got=%h want=9999", score); end
    pulse_hit(1);
    checks++; if (score !== 16'h9999) begin failures++; $display("FAIL saturate got=%h want=9999", score); end
  endtask
  task automatic test_reset_mid;
    int t0;
    pulse_miss;
    pulse_miss;
    pulse_miss;
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL miss_out got=%0d want=3", state); end
    vs_frame;
    vs_frame;
    press_button;
    pulse_hit(42);
    press_button;
    checks++; if (state !== 2'd2 || score !== 16'h0042) begin failures++; $display("FAIL pre_reset got=%0d/%h want=2/0042", state, score); end
    vs = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    #2;
    checks++; if (state !== 2'd0 || score !== 16'h0000 || lives !== 2'd0) begin failures++; $display("FAIL midrst got=%0d/%h/%0d want=0/0000/0", state, score, lives); end
    checks++; if (play_en !== 1'b0 || frame_tick !== 1'b0) begin failures++; $display("FAIL midrst_outs got=%b%b want=00", play_en, frame_tick); end
    cyc(2);
    t0 = ticks;
    rst_n = 1'b1;
    cyc(10);
    checks++; if (ticks !== t0) begin failures++; $display("FAIL spurious_tick got=%0d want=%0d", ticks, t0); end
    pulse_hit(1);
    checks++; if (state !== 2'd0 || score !== 16'h0000) begin failures++; $display("FAIL no_restart got=%0d/%h want=0/0000", state, score); end
    vs = 1'b1;
    cyc(5);
    vs = 1'b0;
    cyc(6);
    checks++; if (ticks !== t0 + 1) begin failures++; $display("FAIL next_tick got=%0d want=%0d", ticks, t0 + 1); end
  endtask
  initial begin
    test_reset;
    test_start;
    test_hits;
    test_pause;
    test_miss;
    test_over;
    test_saturate;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable clk cycles needed to accept a new button level.
REQ-002 Parameter START_LIVES, default 3, lives loaded at game start; legal range 1..3.
REQ-003 Parameter OVER_FRAMES, default 120, frame ticks spent in OVER before returning to IDLE.
REQ-004 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system/pixel clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 button  in  1  raw, asynchronous, bouncy push-button, high = pressed.
REQ-008 vs  in  1  vertical sync from the VGA timing generator, active-low pulse.
REQ-009 hit  in  1  one-cycle pulse from pixel/game logic: target scored.
REQ-010 miss  in  1  one-cycle pulse from pixel/game logic: target missed.
REQ-011 play_en  out  1  high only in PLAY; gates object motion in the pixel logic.
REQ-012 state  out  2  current FSM state encoding.
REQ-013 score  out  16  four packed BCD digits, [15:12] most significant; feeds the 7-segment scanner.
REQ-014 lives  out  2  remaining lives, binary.
REQ-015 frame_tick  out  1  one-cycle pulse per frame.

Function
REQ-016 button and vs SHALL each pass through a 2-flop synchronizer before any use.
REQ-017 Debounced level SHALL change only after the synchronized button differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the old level clears the count.
REQ-018 press SHALL be an internal one-cycle pulse on each 0->1 transition of the debounced level; release generates nothing.
REQ-019 frame_tick SHALL pulse for one cycle on each 1->0 transition of synchronized vs.
REQ-020 States: IDLE=0, PLAY=1, PAUSE=2, OVER=3; state output is registered.
REQ-021 IDLE: on press -> PLAY, score <= 0x0000, lives <= START_LIVES, same edge.
REQ-022 PLAY: hit -> score BCD+1; miss -> lives-1; press -> PAUSE.
REQ-023 PLAY, miss with lives==1 -> OVER, lives <= 0.
REQ-024 PLAY, hit and miss same cycle: both applied (score increments, lives decrements, OVER if lives reaches 0).
REQ-025 PLAY, press with hit/miss same cycle: hit/miss applied, then PAUSE; if the miss ends the game, OVER wins over PAUSE.
REQ-026 PAUSE: press -> PLAY; hit and miss ignored; score and lives held.
REQ-027 OVER: frame counter cleared on entry; after OVER_FRAMES frame_ticks -> IDLE; press, hit, miss ignored; score held until next game start.
REQ-028 IDLE: hit and miss ignored; score and lives hold last game's values.
REQ-029 BCD increment: digit 9 wraps to 0 with carry to next digit; 0x9999 saturates (hit ignored).
REQ-030 play_en SHALL be combinationally (state==PLAY) from the registered state; no other outputs are combinational.

Reset
REQ-031 On rst_n low: state IDLE, score 0x0000, lives 0, play_en 0, frame_tick 0, debounced level 0, debounce and frame counters 0.
REQ-032 vs synchronizer flops SHALL reset to 1 so no spurious frame_tick follows reset; button synchronizer flops reset to 0.
REQ-033 Reset asserted mid-game SHALL abandon the game immediately; after release only a fresh debounced press starts PLAY.

Structure
REQ-034 Package game_pkg SHALL hold the state encoding constants, the BCD digit width, and the default START_LIVES/OVER_FRAMES values.
REQ-035 Sub-module button_debounce (synchronizer + debounce counter + press pulse, parameterized by DEBOUNCE_CYCLES) SHALL be instantiated once.

Verification (DEBOUNCE_CYCLES=4, OVER_FRAMES=2)
REQ-036 Reset, button held high 3 cycles then bounced low, then high 6 cycles -> exactly one press; state IDLE->PLAY, lives=3, score=0x0000.
REQ-037 In PLAY, 10 hit pulses from score 0x0095 -> score 0x0105; 1 hit at 0x9999 -> stays 0x9999.
REQ-038 In PLAY, lives=1, hit and miss same cycle -> score +1, lives=0, state OVER, play_en=0; after 2 vs falling edges -> IDLE.
REQ-039 PLAY, press -> PAUSE; hit/miss pulses -> score/lives unchanged; press -> PLAY.
REQ-040 Assert rst_n in PAUSE with score 0x0042 -> all outputs at reset values; vs held low through reset release -> no frame_tick until next 1->0 of vs.
